// File: rtl/bck_token_issuer.sv
// Backward-extension token issuer: one BCK_INI token per job, then BCK_RUN sweeps paced by feedback.
// Optional perf counters are enabled by defining BCK_ISSUE_PERF_EN.
module bck_token_issuer #(
    parameter int unsigned READ_NUM_WIDTH = 6,
    parameter int unsigned MAX_SIZE       = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [READ_NUM_WIDTH-1:0] job_read_num,
    input  logic [63:0]               job_primary,
    input  logic [6:0]                job_forward_size_n,
    input  logic [6:0]                job_init_size,
    input  logic [6:0]                job_start_i,
    input  logic [6:0]                job_min_intv,
    input  logic                      fb_valid,
    input  logic [6:0]                fb_new_size,
    output logic [5:0]                status,
    output logic [READ_NUM_WIDTH-1:0] read_num,
    output logic [63:0]               primary,
    output logic [6:0]                forward_size_n,
    output logic [6:0]                min_intv,
    output logic [6:0]                new_last_size,
    output logic [6:0]                backward_i,
    output logic [6:0]                backward_j,
    output logic [6:0]                current_wr_addr,
    output logic                      iteration_boundary,
    output logic                      job_done,
    output logic                      fb_err
`ifdef BCK_ISSUE_PERF_EN
    ,
    output logic [31:0]               perf_tokens,
    output logic [31:0]               perf_stalls
`endif
);

    localparam logic [5:0] ST_BUBBLE = 6'b000000;
    localparam logic [5:0] ST_INI    = 6'b001000;
    localparam logic [5:0] ST_RUN    = 6'b010000;
    localparam logic [6:0] MAX_SZ    = 7'(MAX_SIZE);

    typedef enum logic [1:0] {StIdle, StIni, StRun, StWaitFb} state_e;

    state_e                    state_q, state_d;
    logic [READ_NUM_WIDTH-1:0] read_num_q, read_num_d;
    logic [63:0]               primary_q, primary_d;
    logic [6:0]                fwd_q, fwd_d, min_intv_q, min_intv_d;
    logic [6:0]                start_i_q, start_i_d, init_size_q, init_size_d;
    logic [6:0]                cnt_q, cnt_d;
    logic [5:0]                status_q, status_d;
    logic [6:0]                bi_q, bi_d, bj_q, bj_d, size_q, size_d, wr_q, wr_d;
    logic                      ib_q, ib_d, done_q, done_d, err_q, err_d;
    logic                      pend_q, pend_d;
    logic [6:0]                pend_size_q, pend_size_d;
    logic [6:0]                fb_clamped, fb_size;
    logic                      fb_hit;

    assign fb_clamped = (fb_new_size > MAX_SZ) ? MAX_SZ : fb_new_size;
    assign fb_hit     = pend_q | (fb_valid & (state_q == StWaitFb));
    assign fb_size    = pend_q ? pend_size_q : fb_clamped;
    // The cycle that shows job_done never accepts a job, so the two never overlap.
    assign job_ready  = (state_q == StIdle) & ~stall & ~done_q;

    always_comb begin
        state_d     = state_q;
        read_num_d  = read_num_q;
        primary_d   = primary_q;
        fwd_d       = fwd_q;
        min_intv_d  = min_intv_q;
        start_i_d   = start_i_q;
        init_size_d = init_size_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        bi_d        = bi_q;
        bj_d        = bj_q;
        size_d      = size_q;
        wr_d        = wr_q;
        ib_d        = ib_q;
        done_d      = done_q;
        err_d       = err_q;
        pend_d      = pend_q;
        pend_size_d = pend_size_q;

        if (fb_valid && (state_q != StWaitFb || fb_new_size > MAX_SZ || pend_q)) begin
            err_d = 1'b1;
        end

        if (stall) begin
            if (fb_valid && state_q == StWaitFb && !pend_q) begin
                pend_d      = 1'b1;
                pend_size_d = fb_clamped;
            end
        end else begin
            done_d   = 1'b0;
            status_d = ST_BUBBLE;
            ib_d     = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (job_valid && job_ready) begin
                        read_num_d  = job_read_num;
                        primary_d   = job_primary;
                        fwd_d       = job_forward_size_n;
                        min_intv_d  = job_min_intv;
                        start_i_d   = job_start_i;
                        init_size_d = job_init_size;
                        state_d     = StIni;
                    end
                end
                StIni: begin
                    status_d = ST_INI;
                    bi_d     = start_i_q;
                    bj_d     = 7'd0;
                    size_d   = init_size_q;
                    wr_d     = fwd_q - 7'd1;
                    ib_d     = (start_i_q == 7'd0);
                    cnt_d    = 7'd0;
                    state_d  = StRun;
                end
                StRun: begin
                    // An empty job reaches here with size 0 and only finishes.
                    if (size_q == 7'd0) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        status_d = ST_RUN;
                        bj_d     = cnt_q;
                        ib_d     = (bi_q == 7'd0);
                        cnt_d    = cnt_q + 7'd1;
                        if (cnt_q == size_q - 7'd1) state_d = StWaitFb;
                    end
                end
                StWaitFb: begin
                    if (fb_hit) begin
                        pend_d = 1'b0;
                        if (fb_size == 7'd0 || bi_q == 7'd0) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            status_d = ST_RUN;
                            bi_d     = bi_q - 7'd1;
                            bj_d     = 7'd0;
                            size_d   = fb_size;
                            wr_d     = fwd_q - 7'd1;
                            ib_d     = (bi_q == 7'd1);
                            cnt_d    = 7'd1;
                            state_d  = (fb_size == 7'd1) ? StWaitFb : StRun;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            read_num_q  <= '0;
            primary_q   <= '0;
            fwd_q       <= '0;
            min_intv_q  <= '0;
            start_i_q   <= '0;
            init_size_q <= '0;
            cnt_q       <= '0;
            status_q    <= ST_BUBBLE;
            bi_q        <= '0;
            bj_q        <= '0;
            size_q      <= '0;
            wr_q        <= '0;
            ib_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_size_q <= '0;
        end else begin
            state_q     <= state_d;
            read_num_q  <= read_num_d;
            primary_q   <= primary_d;
            fwd_q       <= fwd_d;
            min_intv_q  <= min_intv_d;
            start_i_q   <= start_i_d;
            init_size_q <= init_size_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
            bi_q        <= bi_d;
            bj_q        <= bj_d;
            size_q      <= size_d;
            wr_q        <= wr_d;
            ib_q        <= ib_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            pend_size_q <= pend_size_d;
        end
    end

    assign status             = status_q;
    assign read_num           = read_num_q;
    assign primary            = primary_q;
    assign forward_size_n     = fwd_q;
    assign min_intv           = min_intv_q;
    assign new_last_size      = size_q;
    assign backward_i         = bi_q;
    assign backward_j         = bj_q;
    assign current_wr_addr    = wr_q;
    assign iteration_boundary = ib_q;
    // A pulse caught by a stall stays pending and shows on the first free cycle.
    assign job_done           = done_q & ~stall;
    assign fb_err             = err_q;

`ifdef BCK_ISSUE_PERF_EN
    logic [31:0] tokens_q, stalls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tokens_q <= '0;
            stalls_q <= '0;
        end else begin
            if (!stall && status_d != ST_BUBBLE && tokens_q != '1) tokens_q <= tokens_q + 32'd1;
            if (stall && state_q != StIdle && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_tokens = tokens_q;
    assign perf_stalls = stalls_q;
`endif

endmodule
